fetch_unit: RTL and testbench

//  Instruction fetch stage; sits upstream of decode and the control-transfer unit.
//  - Holds the architectural fetch PC and issues 32-bit instruction reads to imem (req/gnt/rvalid).
//  - Predicts branch direction and target, buffers fetched words, and hands {instn, pc_plus_4, pr_taken} to decode.
//  - Accepts redirects (force_rdr / next_pc) from the CTU and flushes wrong-path work.

---
 rtl/core_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 44 ++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared fetch-stage opcodes, buffer entry type and branch-history counter helpers
package core_pkg;
    localparam logic [5:0] OP_BR          = 6'h30;
    localparam logic [5:0] OP_BSR         = 6'h34;
    localparam logic [5:0] OP_BRANCH_BASE = 6'h30;
    typedef struct packed {
        logic [31:0] instn;
        logic [63:0] pc_plus_4;
        logic        pr_taken;
    } fb_entry_t;
    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t BHT_INIT = 2'b01;
    function automatic bht_ctr_t bht_next(bht_ctr_t c, logic taken);
        return taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
    endfunction
    function automatic logic is_branch(logic [5:0] op);
        return op[5:4] == OP_BRANCH_BASE[5:4];
    endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular FIFO of fetched entries; flush empties it, pop on empty is ignored
module fetch_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  fb_entry_t               i_data,
    output fb_entry_t               o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    fb_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_rd;
    logic [AW-1:0]  r_wr;
    logic [AW:0]    r_count;
    logic           w_pop;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    // head reads as zero while empty so decode sees clean values after reset/flush
    assign o_head  = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (reset | i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, w_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, single-outstanding imem reads, branch prediction and decode buffer.
// FETCH_BHT_EN selects a 2-bit-counter BHT; otherwise static backward-taken prediction.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          FB_DEPTH    = 2,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instn,
    output logic [63:0] dec_pc_plus_4,
    output logic        dec_pr_taken,
    input  logic        bht_upd,
    input  logic [63:0] bht_upd_pc,
    input  logic        bht_upd_taken
);
    logic [63:0]                r_pc;
    logic                       r_pending;
    logic                       r_drop;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_grant;
    logic                       w_push;
    logic                       w_pt;
    logic                       w_dir;
    logic                       w_live;
    logic                       w_unused;
    logic [$clog2(FB_DEPTH):0]  w_count;
    logic [5:0]                 w_op;
    logic [63:0]                w_pc4;
    logic [63:0]                w_target;
    fb_entry_t                  w_head;
    fb_entry_t                  w_entry;
    assign imem_req  = ~reset & ~r_pending & ~r_drop & ~w_full & ~redirect;
    assign imem_addr = r_pc;
    assign w_grant   = imem_req & imem_gnt;
    assign w_push    = imem_rvalid & ~r_drop & ~redirect;
    // a response is still in flight after this cycle; it must be discarded when it lands
    assign w_live    = (r_pending | r_drop) & ~imem_rvalid;
    assign w_op      = imem_rdata[31:26];
    assign w_pc4     = r_pc + 64'd4;
    assign w_target  = w_pc4 + {{41{imem_rdata[20]}}, imem_rdata[20:0], 2'b00};
    assign w_pt      = is_branch(w_op) & ((w_op == OP_BR) | (w_op == OP_BSR) | w_dir);
    assign w_entry   = '{instn: imem_rdata, pc_plus_4: w_pc4, pr_taken: w_pt};
`ifdef FETCH_BHT_EN
    localparam int BI = $clog2(BHT_ENTRIES);
    bht_ctr_t r_bht [BHT_ENTRIES];
    assign w_dir    = r_bht[r_pc[BI+1:2]][1];
    assign w_unused = ^{redirect_pc[1:0], bht_upd_pc[63:BI+2], bht_upd_pc[1:0], w_count};
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= BHT_INIT;
        end else if (bht_upd) begin
            r_bht[bht_upd_pc[BI+1:2]] <= bht_next(r_bht[bht_upd_pc[BI+1:2]], bht_upd_taken);
        end
    end
`else
    assign w_dir    = imem_rdata[20];
    assign w_unused = ^{redirect_pc[1:0], bht_upd, bht_upd_pc, bht_upd_taken, w_count, BHT_ENTRIES[0]};
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= {RESET_PC[63:2], 2'b00};
            r_pending <= 1'b0;
            r_drop    <= w_live;
        end else if (redirect) begin
            r_pc      <= {redirect_pc[63:2], 2'b00};
            r_pending <= r_pending & ~imem_rvalid;
            r_drop    <= w_live;
        end else begin
            if (w_push) r_pc <= w_pt ? w_target : w_pc4;
            r_pending <= w_grant | (r_pending & ~imem_rvalid);
            r_drop    <= r_drop & ~imem_rvalid;
        end
    end
    fetch_buffer #(.DEPTH(FB_DEPTH)) u_fb (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (dec_ready),
        .i_flush (redirect),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    assign dec_valid     = ~w_empty;
    assign dec_instn     = w_head.instn;
    assign dec_pc_plus_4 = w_head.pc_plus_4;
    assign dec_pr_taken  = w_head.pr_taken;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a latency-configurable imem model
module tb_fetch_unit;
    import core_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instn;
    logic [63:0] dec_pc_plus_4;
    logic        dec_pr_taken;
    logic        bht_upd = 1'b0;
    logic [63:0] bht_upd_pc = '0;
    logic        bht_upd_taken = 1'b0;
    logic        fb_push = 1'b0;
    logic        fb_pop = 1'b0;
    logic        fb_flush = 1'b0;
    fb_entry_t   fb_in = '0;
    fb_entry_t   fb_head;
    logic        fb_full;
    logic        fb_empty;
    logic [1:0]  fb_cnt;
    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          wait_n = 0;
    bit          busy = 1'b0;
    logic [63:0] busy_addr = '0;
    logic [63:0] gnt_q [$];
    logic [63:0] pc4_q [$];
    logic [31:0] ins_q [$];
    logic        pt_q [$];

    fetch_unit #(.RESET_PC(64'h1000), .FB_DEPTH(2), .BHT_ENTRIES(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instn     (dec_instn),
        .dec_pc_plus_4 (dec_pc_plus_4),
        .dec_pr_taken  (dec_pr_taken),
        .bht_upd       (bht_upd),
        .bht_upd_pc    (bht_upd_pc),
        .bht_upd_taken (bht_upd_taken)
    );

    fetch_buffer #(.DEPTH(2)) u_fb_tb (
        .clk     (clk),
        .reset   (reset),
        .i_push  (fb_push),
        .i_pop   (fb_pop),
        .i_flush (fb_flush),
        .i_data  (fb_in),
        .o_head  (fb_head),
        .o_full  (fb_full),
        .o_empty (fb_empty),
        .o_count (fb_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!reset) assert (!(dut.w_push && dut.w_full && !dec_ready)) else $error("FAIL push_into_full");

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] word(logic [63:0] a);
        case (a)
            64'h2000: return 32'hC01F_FFFC;
            64'h5000: return 32'hE420_0008;
            64'h6010: return 32'hE43F_FFFE;
            64'h7000: return 32'h681F_FFFF;
            64'h7100: return 32'hD000_0010;
            default:  return {6'h04, a[27:2]};
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic        g;
        logic [63:0] a;
        @(negedge clk);
        g = imem_req & imem_gnt;
        a = imem_addr;
        if (g) gnt_q.push_back(a);
        if (dec_valid && dec_ready) begin
            pc4_q.push_back(dec_pc_plus_4);
            ins_q.push_back(dec_instn);
            pt_q.push_back(dec_pr_taken);
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (g) begin
            busy = 1'b1;
            busy_addr = a;
            wait_n = lat - 1;
        end
        if (busy) begin
            if (wait_n == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = word(busy_addr);
                busy = 1'b0;
            end else wait_n--;
        end
    endtask

    task automatic clear_q();
        gnt_q.delete();
        pc4_q.delete();
        ins_q.delete();
        pt_q.delete();
    endtask

    task automatic run_until(string tag, int ng, int np);
        int n = 0;
        while ((gnt_q.size() < ng || pc4_q.size() < np) && n < 80) begin
            tick();
            n++;
        end
        check({tag, "_done"}, (gnt_q.size() >= ng && pc4_q.size() >= np), 1);
    endtask

    task automatic wait_grant(string tag);
        int n = 0;
        gnt_q.delete();
        while (gnt_q.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_grant"}, gnt_q.size(), 1);
    endtask

    task automatic go(logic [63:0] a);
        redirect = 1'b1;
        redirect_pc = a;
        tick();
        redirect = 1'b0;
        clear_q();
    endtask

    initial begin
        tick();
        tick();
        check("rst_req", imem_req, 0);
        check("rst_valid", dec_valid, 0);
        check("rst_instn", dec_instn, 0);
        check("rst_pc4", dec_pc_plus_4, 0);
        check("rst_pt", dec_pr_taken, 0);
        reset = 1'b0;
        clear_q();
        run_until("seq", 3, 3);
        check("seq_a0", gnt_q[0], 64'h1000);
        check("seq_a1", gnt_q[1], 64'h1004);
        check("seq_a2", gnt_q[2], 64'h1008);
        check("seq_p0", pc4_q[0], 64'h1004);
        check("seq_p1", pc4_q[1], 64'h1008);
        check("seq_p2", pc4_q[2], 64'h100C);
        check("seq_i0", ins_q[0], 32'h1000_0400);
        check("seq_t0", pt_q[0], 0);
        check("seq_t2", pt_q[2], 0);
        go(64'h2000);
        run_until("br", 2, 2);
        check("br_a0", gnt_q[0], 64'h2000);
        check("br_a1", gnt_q[1], 64'h1FF4);
        check("br_i0", ins_q[0], 32'hC01F_FFFC);
        check("br_p0", pc4_q[0], 64'h2004);
        check("br_t0", pt_q[0], 1);
        check("br_p1", pc4_q[1], 64'h1FF8);
        check("br_t1", pt_q[1], 0);
        lat = 3;
        wait_grant("rdr");
        redirect = 1'b1;
        redirect_pc = 64'h4003;
        tick();
        redirect = 1'b0;
        check("rdr_empty", dec_valid, 0);
        check("rdr_addr", imem_addr, 64'h4000);
        clear_q();
        run_until("rdr", 1, 1);
        check("rdr_a0", gnt_q[0], 64'h4000);
        check("rdr_p0", pc4_q[0], 64'h4004);
        check("rdr_i0", ins_q[0], 32'h1000_1000);
        lat = 1;
        dec_ready = 1'b0;
        go(64'h3000);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 3) check("stall_hold", dec_pc_plus_4, 64'h3004);
        end
        check("stall_req", imem_req, 0);
        check("stall_valid", dec_valid, 1);
        check("stall_count", dut.w_count, 2);
        check("stall_instn", dec_instn, 32'h1000_0C00);
        check("stall_grants", gnt_q.size(), 2);
        dec_ready = 1'b1;
        run_until("drain", 0, 3);
        check("drain_p0", pc4_q[0], 64'h3004);
        check("drain_p1", pc4_q[1], 64'h3008);
        check("drain_p2", pc4_q[2], 64'h300C);
        fb_push = 1'b1;
        fb_in = '{32'hAAAA_0001, 64'h1, 1'b0};
        tick();
        fb_in = '{32'hAAAA_0002, 64'h2, 1'b1};
        tick();
        check("fb_full", fb_full, 1);
        check("fb_cnt_full", fb_cnt, 2);
        check("fb_head_a", fb_head.instn, 32'hAAAA_0001);
        fb_pop = 1'b1;
        fb_in = '{32'hAAAA_0003, 64'h3, 1'b0};
        tick();
        fb_push = 1'b0;
        check("fb_cnt_pp", fb_cnt, 2);
        check("fb_head_b", fb_head.pc_plus_4, 64'h2);
        tick();
        check("fb_head_c", fb_head.instn, 32'hAAAA_0003);
        tick();
        check("fb_empty", fb_empty, 1);
        tick();
        check("fb_pop_empty", fb_cnt, 0);
        fb_pop = 1'b0;
        bht_upd = 1'b1;
        bht_upd_pc = 64'h5000;
        bht_upd_taken = 1'b1;
        tick();
        tick();
        bht_upd = 1'b0;
        go(64'h5000);
        run_until("beq", 2, 1);
`ifdef FETCH_BHT_EN
        check("beq_next", gnt_q[1], 64'h5024);
        check("beq_pt", pt_q[0], 1);
`else
        check("beq_next", gnt_q[1], 64'h5004);
        check("beq_pt", pt_q[0], 0);
`endif
        go(64'h6010);
        run_until("bwd", 2, 1);
`ifdef FETCH_BHT_EN
        check("bwd_next", gnt_q[1], 64'h6014);
        check("bwd_pt", pt_q[0], 0);
`else
        check("bwd_next", gnt_q[1], 64'h600C);
        check("bwd_pt", pt_q[0], 1);
`endif
        go(64'h7000);
        run_until("jmp", 2, 1);
        check("jmp_next", gnt_q[1], 64'h7004);
        check("jmp_pt", pt_q[0], 0);
        go(64'h7100);
        run_until("bsr", 2, 1);
        check("bsr_next", gnt_q[1], 64'h7144);
        check("bsr_pt", pt_q[0], 1);
        go(64'hFFFF_FFFF_FFFF_FFFC);
        run_until("wrap", 2, 1);
        check("wrap_a0", gnt_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_a1", gnt_q[1], 64'h0);
        check("wrap_p0", pc4_q[0], 64'h0);
        lat = 3;
        wait_grant("mrst");
        reset = 1'b1;
        tick();
        check("mrst_req", imem_req, 0);
        check("mrst_valid", dec_valid, 0);
        reset = 1'b0;
        clear_q();
        run_until("mrst", 1, 1);
        check("mrst_a0", gnt_q[0], 64'h1000);
        check("mrst_p0", pc4_q[0], 64'h1004);
        check("mrst_i0", ins_q[0], 32'h1000_0400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
